// File: rtl/trivium_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trivium_pkg
// Description : Shared sizes, controller state encoding and register-C init
//               constant for the Trivium controller slice.
// Revision    : 1.0 - initial release
// ============================================================================
package trivium_pkg;

    localparam int KEY_BITS        = 80;
    localparam int IV_BITS         = 80;
    localparam int KEY_BYTES       = KEY_BITS / 8;
    localparam int IV_BYTES        = 10;
    localparam int KV_BYTES        = KEY_BYTES + IV_BYTES;
    localparam int KV_CNT_W        = $clog2(KV_BYTES + 1);

    localparam int REG_A_SZ_DEF    = 93;
    localparam int REG_B_SZ_DEF    = 84;
    localparam int REG_C_SZ_DEF    = 111;
    localparam int INIT_CYCLES_DEF = 1152;

    // Register C loads all zeros except its three most significant bits
    localparam logic [2:0] C_REG_C_TAIL = 3'b111;

    typedef enum logic [2:0] {
        ST_KEY  = 3'd0,
        ST_IV   = 3'd1,
        ST_LOAD = 3'd2,
        ST_WARM = 3'd3,
        ST_IDLE = 3'd4,
        ST_GEN  = 3'd5,
        ST_OUT  = 3'd6
    } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/trivium_kv_buf.sv
`default_nettype none
// ============================================================================
// Module      : trivium_kv_buf
// Description : Byte-serial collector for the 80-bit key followed by the
//               80-bit IV, with byte counter and synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module trivium_kv_buf
    import trivium_pkg::*;
(
    input  logic                clk_i,
    input  logic                n_rst_i,
    input  logic                clr_i,
    input  logic                we_i,
    input  logic [7:0]          dat_i,
    output logic [KEY_BITS-1:0] key_o,
    output logic [IV_BITS-1:0]  iv_o,
    output logic [KV_CNT_W-1:0] cnt_o
);

    logic [KEY_BITS+IV_BITS-1:0] r_buf;
    logic [KV_CNT_W-1:0]         r_cnt;

    // Byte n lands at bits 8n..8n+7: key bytes first, IV bytes above them
    always_ff @(posedge clk_i) begin
        if (!n_rst_i || clr_i) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else if (we_i && (r_cnt < KV_CNT_W'(KV_BYTES))) begin
            r_buf[{r_cnt, 3'b000} +: 8] <= dat_i;
            r_cnt                       <= r_cnt + KV_CNT_W'(1);
        end
    end

    assign key_o = r_buf[KEY_BITS-1:0];
    assign iv_o  = r_buf[KEY_BITS+IV_BITS-1:KEY_BITS];
    assign cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: rtl/trivium_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trivium_ctrl
// Description : Key/IV collection, load, warm-up and byte encryption control
//               for the three Trivium shift registers.
// Revision    : 1.0 - initial release
// ============================================================================
module trivium_ctrl
    import trivium_pkg::*;
#(
    parameter int INIT_CYCLES = INIT_CYCLES_DEF,
    parameter int REG_A_SZ    = REG_A_SZ_DEF,
    parameter int REG_B_SZ    = REG_B_SZ_DEF,
    parameter int REG_C_SZ    = REG_C_SZ_DEF
)
(
    input  logic                clk_i,
    input  logic                n_rst_i,
    input  logic                rekey_i,
    input  logic [7:0]          kv_dat_i,
    input  logic                kv_valid_i,
    output logic                kv_ready_o,
    input  logic [7:0]          pt_dat_i,
    input  logic                pt_valid_i,
    output logic                pt_ready_o,
    output logic [7:0]          ct_dat_o,
    output logic                ct_valid_o,
    input  logic                ct_ready_i,
    input  logic                z_i,
    output logic                ce_o,
    output logic                ld_o,
    output logic [REG_A_SZ-1:0] ld_a_o,
    output logic [REG_B_SZ-1:0] ld_b_o,
    output logic [REG_C_SZ-1:0] ld_c_o,
    output logic                init_done_o
);

    localparam int WARM_W = $clog2(INIT_CYCLES + 1);

    ctrl_state_t         r_state;
    logic [WARM_W-1:0]   r_warm_cnt;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_pt;
    logic [6:0]          r_ks;
    logic                r_kv_ready;
    logic                r_pt_ready;
    logic                r_ce;
    logic                r_ld;
    logic                r_ct_valid;
    logic [7:0]          r_ct_dat;
    logic                r_init_done;

    logic                w_kv_acc;
    logic [KEY_BITS-1:0] w_key;
    logic [IV_BITS-1:0]  w_iv;
    logic [KV_CNT_W-1:0] w_kv_cnt;

    assign w_kv_acc = kv_valid_i && r_kv_ready && !rekey_i;

    trivium_kv_buf u_kv_buf (
        .clk_i   (clk_i),
        .n_rst_i (n_rst_i),
        .clr_i   (rekey_i),
        .we_i    (w_kv_acc),
        .dat_i   (kv_dat_i),
        .key_o   (w_key),
        .iv_o    (w_iv),
        .cnt_o   (w_kv_cnt)
    );

    // The buffer is frozen once collection ends, so the vectors stay stable
    assign ld_a_o = REG_A_SZ'(w_key);
    assign ld_b_o = REG_B_SZ'(w_iv);

    always_comb begin
        ld_c_o                    = '0;
        ld_c_o[REG_C_SZ-1 -: 3]   = C_REG_C_TAIL;
    end

    always_ff @(posedge clk_i) begin
        if (!n_rst_i || rekey_i) begin
            r_state     <= ST_KEY;
            r_warm_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_pt        <= '0;
            r_ks        <= '0;
            r_kv_ready  <= 1'b1;
            r_pt_ready  <= 1'b0;
            r_ce        <= 1'b0;
            r_ld        <= 1'b0;
            r_ct_valid  <= 1'b0;
            r_ct_dat    <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_KEY: begin
                    if (w_kv_acc && (w_kv_cnt == KV_CNT_W'(KEY_BYTES - 1))) begin
                        r_state <= ST_IV;
                    end
                end
                ST_IV: begin
                    if (w_kv_acc && (w_kv_cnt == KV_CNT_W'(KV_BYTES - 1))) begin
                        r_state    <= ST_LOAD;
                        r_kv_ready <= 1'b0;
                        r_ld       <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_ld       <= 1'b0;
                    r_ce       <= 1'b1;
                    r_warm_cnt <= '0;
                    r_state    <= ST_WARM;
                end
                ST_WARM: begin
                    if (r_warm_cnt == WARM_W'(INIT_CYCLES - 1)) begin
                        r_ce        <= 1'b0;
                        r_init_done <= 1'b1;
                        r_pt_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_warm_cnt <= r_warm_cnt + WARM_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (pt_valid_i) begin
                        r_pt       <= pt_dat_i;
                        r_pt_ready <= 1'b0;
                        r_ce       <= 1'b1;
                        r_bit_cnt  <= '0;
                        r_state    <= ST_GEN;
                    end
                end
                ST_GEN: begin
                    // z is sampled before the shift; sample k ends up in bit k
                    r_ks      <= {z_i, r_ks[6:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_ce       <= 1'b0;
                        r_ct_valid <= 1'b1;
                        r_ct_dat   <= r_pt ^ {z_i, r_ks};
                        r_state    <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (ct_ready_i) begin
                        r_ct_valid <= 1'b0;
                        r_pt_ready <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_KEY;
                end
            endcase
        end
    end

    assign kv_ready_o  = r_kv_ready;
    assign pt_ready_o  = r_pt_ready;
    assign ce_o        = r_ce;
    assign ld_o        = r_ld;
    assign ct_valid_o  = r_ct_valid;
    assign ct_dat_o    = r_ct_dat;
    assign init_done_o = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_trivium_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_trivium_ctrl
// Description : Randomized scoreboard bench for trivium_ctrl with a stubbed
//               keystream input.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trivium_ctrl;

    localparam int INIT_CYCLES = 1152;

    logic         clk_i      = 1'b0;
    logic         n_rst_i    = 1'b0;
    logic         rekey_i    = 1'b0;
    logic [7:0]   kv_dat_i   = '0;
    logic         kv_valid_i = 1'b0;
    logic         kv_ready_o;
    logic [7:0]   pt_dat_i   = '0;
    logic         pt_valid_i = 1'b0;
    logic         pt_ready_o;
    logic [7:0]   ct_dat_o;
    logic         ct_valid_o;
    logic         ct_ready_i = 1'b0;
    logic         z_i        = 1'b0;
    logic         ce_o;
    logic         ld_o;
    logic [92:0]  ld_a_o;
    logic [83:0]  ld_b_o;
    logic [110:0] ld_c_o;
    logic         init_done_o;

    int           n_checks  = 0;
    int           n_pass    = 0;
    int           stall_req = 0;
    logic [7:0]   exp_q[$];
    logic [7:0]   kv_bytes[20];

    trivium_ctrl #(.INIT_CYCLES(INIT_CYCLES)) dut (
        .clk_i       (clk_i),
        .n_rst_i     (n_rst_i),
        .rekey_i     (rekey_i),
        .kv_dat_i    (kv_dat_i),
        .kv_valid_i  (kv_valid_i),
        .kv_ready_o  (kv_ready_o),
        .pt_dat_i    (pt_dat_i),
        .pt_valid_i  (pt_valid_i),
        .pt_ready_o  (pt_ready_o),
        .ct_dat_o    (ct_dat_o),
        .ct_valid_o  (ct_valid_o),
        .ct_ready_i  (ct_ready_i),
        .z_i         (z_i),
        .ce_o        (ce_o),
        .ld_o        (ld_o),
        .ld_a_o      (ld_a_o),
        .ld_b_o      (ld_b_o),
        .ld_c_o      (ld_c_o),
        .init_done_o (init_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got no/unexpected event, expected the specified handshake", name);
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic rand_kv();
        for (int i = 0; i < 20; i++) kv_bytes[i] = 8'($urandom);
    endtask

    // Sends bytes 0..nbytes-1; returns at the negedge one cycle after the last accept
    task automatic send_kv(input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            int budget;
            while ($urandom_range(0, 3) == 0) begin
                kv_valid_i = 1'b0;
                kv_dat_i   = 8'($urandom);
                tick();
            end
            kv_valid_i = 1'b1;
            kv_dat_i   = kv_bytes[i];
            budget     = 0;
            while (!kv_ready_o && budget < 50) begin
                tick();
                budget++;
            end
            if (!kv_ready_o) fail_now("kv_ready_timeout");
            tick();
        end
        kv_valid_i = 1'b0;
    endtask

    task automatic load_and_warm();
        logic [79:0] k;
        logic [79:0] v;
        int          cnt;
        for (int n = 0; n < 10; n++) begin
            k[8*n +: 8] = kv_bytes[n];
            v[8*n +: 8] = kv_bytes[10+n];
        end
        send_kv(20);
        check("ld_pulse", ld_o, 1'b1);
        check("ld_ce_low", ce_o, 1'b0);
        check("ld_a", ld_a_o, {13'b0, k});
        check("ld_b", ld_b_o, {4'b0, v});
        check("ld_c", ld_c_o, {3'b111, 108'b0});
        tick();
        check("ld_single", ld_o, 1'b0);
        cnt = 0;
        while (ce_o && cnt < 5000) begin
            cnt++;
            kv_valid_i = 1'($urandom);
            kv_dat_i   = 8'($urandom);
            tick();
        end
        kv_valid_i = 1'b0;
        check("warm_len", cnt, INIT_CYCLES);
        check("init_done_rise", init_done_o, 1'b1);
        check("pt_ready_rise", pt_ready_o, 1'b1);
        check("ld_a_stable", ld_a_o, {13'b0, k});
        check("ld_b_stable", ld_b_o, {4'b0, v});
    endtask

    // Keystream bit k is presented on z_i in the k-th cycle after the accept
    task automatic encrypt(input logic [7:0] pt, input logic [7:0] ks, input int stall, input bit do_rekey);
        int budget = 0;
        pt_valid_i = 1'b1;
        pt_dat_i   = pt;
        while (!pt_ready_o && budget < 100) begin
            z_i = 1'($urandom);
            tick();
            budget++;
        end
        if (!pt_ready_o) begin
            fail_now("pt_ready_timeout");
            pt_valid_i = 1'b0;
            return;
        end
        if (!do_rekey) begin
            exp_q.push_back(pt ^ ks);
            stall_req = stall;
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 0) pt_valid_i = 1'($urandom);
            pt_dat_i = 8'($urandom);
            z_i      = ks[k];
            check("gen_ce", ce_o, 1'b1);
            check("gen_no_ct", ct_valid_o, 1'b0);
            if (do_rekey && k == 4) begin
                rekey_i = 1'b1;
                tick();
                rekey_i    = 1'b0;
                pt_valid_i = 1'b0;
                check("rekey_ce", ce_o, 1'b0);
                check("rekey_ld", ld_o, 1'b0);
                check("rekey_kv_ready", kv_ready_o, 1'b1);
                check("rekey_init_done", init_done_o, 1'b0);
                check("rekey_pt_ready", pt_ready_o, 1'b0);
                for (int j = 0; j < 12; j++) begin
                    tick();
                    check("rekey_no_ct", ct_valid_o, 1'b0);
                end
                return;
            end
        end
        tick();
        z_i        = 1'($urandom);
        pt_valid_i = 1'b0;
        check("ct_latency", ct_valid_o, 1'b1);
    endtask

    task automatic drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            tick();
            budget++;
        end
    endtask

    // Output monitor: drives ct_ready, checks hold behaviour and pops the scoreboard
    initial begin : monitor
        logic [7:0] held;
        bit         pending;
        pending = 1'b0;
        held    = '0;
        forever begin
            tick();
            check("ce_ld_exclusive", ce_o & ld_o, 1'b0);
            if (ct_valid_o) begin
                if (pending) check("ct_hold", ct_dat_o, held);
                check("out_ce", ce_o, 1'b0);
                check("out_pt_ready", pt_ready_o, 1'b0);
                if (stall_req > 0) begin
                    ct_ready_i = 1'b0;
                    stall_req--;
                end else begin
                    ct_ready_i = 1'($urandom_range(0, 1));
                end
                if (ct_ready_i) begin
                    if (exp_q.size() == 0) fail_now("ct_unexpected");
                    else check("ct_data", ct_dat_o, exp_q.pop_front());
                    pending = 1'b0;
                end else begin
                    pending = 1'b1;
                    held    = ct_dat_o;
                end
            end else begin
                pending    = 1'b0;
                ct_ready_i = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        repeat (3) tick();
        check("rst_ce", ce_o, 1'b0);
        check("rst_ld", ld_o, 1'b0);
        check("rst_ct_valid", ct_valid_o, 1'b0);
        check("rst_pt_ready", pt_ready_o, 1'b0);
        check("rst_init_done", init_done_o, 1'b0);
        check("rst_ct_dat", ct_dat_o, 8'h00);
        n_rst_i = 1'b1;
        tick();
        check("rst_kv_ready", kv_ready_o, 1'b1);

        // Session interrupted by a 2-cycle reset in the middle of warm-up
        rand_kv();
        send_kv(20);
        repeat (200) tick();
        check("warm_mid_ce", ce_o, 1'b1);
        n_rst_i = 1'b0;
        tick();
        tick();
        check("rst_warm_ce", ce_o, 1'b0);
        check("rst_warm_ld", ld_o, 1'b0);
        check("rst_warm_ct_valid", ct_valid_o, 1'b0);
        check("rst_warm_init_done", init_done_o, 1'b0);
        n_rst_i = 1'b1;
        tick();
        check("rst_warm_kv_ready", kv_ready_o, 1'b1);
        check("rst_warm_ce_after", ce_o, 1'b0);

        // Directed key/IV with a single set bit each
        for (int i = 0; i < 20; i++) kv_bytes[i] = 8'h00;
        kv_bytes[0]  = 8'h01;
        kv_bytes[10] = 8'h80;
        load_and_warm();

        encrypt(8'h00, 8'h05, 0, 1'b0);
        encrypt(8'hFF, 8'h05, 5, 1'b0);
        for (int i = 0; i < 30; i++) encrypt(8'($urandom), 8'($urandom), 0, 1'b0);
        drain();

        encrypt(8'($urandom), 8'($urandom), 0, 1'b1);

        // Abort part way through the IV, then a full random session
        rand_kv();
        send_kv(15);
        rekey_i = 1'b1;
        tick();
        rekey_i = 1'b0;
        check("rekey_iv_kv_ready", kv_ready_o, 1'b1);
        rand_kv();
        load_and_warm();
        for (int i = 0; i < 20; i++) encrypt(8'($urandom), 8'($urandom), $urandom_range(0, 3), 1'b0);
        drain();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
